uart_rx_frame: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/uart_rx_bit_timer.sv | 41 ++++
 rtl/uart_rx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the uart_rx_frame receiver.
// Optional parity support is controlled by the UART_RX_PARITY_EN macro (see uart_rx_frame).
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   // Width of the bit timer: must hold CLKS_PER_BIT-1 without wrapping.
   function automatic int timer_w(input int clks_per_bit);
      return $clog2(clks_per_bit) + 1;
   endfunction

   // Width of the bit counter: must hold DATA_W without wrapping.
   function automatic int count_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

   // Serial bits in one frame: start + data + parity + stop.
   function automatic int frame_bits(input int data_w, input int stop_bits, input int parity_bits);
      return 1 + data_w + parity_bits + stop_bits;
   endfunction

   // Even parity over a zero-extended word: 1 when the word holds an odd number of ones.
   function automatic logic even_par(input logic [31:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for uart_rx_frame. Down-counter holding the cycles left in the
// current serial bit; emits a mid-bit sample strike and a bit-end strike.
// While restart is high the current cycle is taken as position 0 of a bit, so the
// counter already sits at position 1 on the following cycle.
module uart_rx_bit_timer
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int TW           = timer_w(CLKS_PER_BIT)
) (
   input  logic clk_rx,
   input  logic rst_n_rx,
   input  logic restart,
   output logic mid,
   output logic bit_end
);

   localparam int            HALF    = (CLKS_PER_BIT - 1) / 2;
   localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] MID_REM = TW'(CLKS_PER_BIT - 1 - HALF);
   localparam logic [TW-1:0] FIRST   = (CLKS_PER_BIT == 1) ? '0 : TW'(CLKS_PER_BIT - 2);

   logic [TW-1:0] rem;

   // Count down to the terminal count, then reload for the next bit period.
   always_ff @(posedge clk_rx or negedge rst_n_rx) begin
      if (!rst_n_rx) begin
         rem <= '0;
      end else if (restart) begin
         rem <= FIRST;
      end else if (rem == '0) begin
         rem <= LAST;
      end else begin
         rem <= rem - TW'(1);
      end
   end

   assign mid     = (rem == MID_REM);
   assign bit_end = (rem == '0);

endmodule

// File: rtl/uart_rx_frame.sv
// Serial frame receiver: idle-high line, start + DATA_W data (+ even parity) + stop bits,
// CLKS_PER_BIT clocks per bit, mid-bit sampling. Delivers the word with a one-cycle
// valid strobe and reports false start (silently), framing and parity errors.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level (start edge)
// START  | inside start bit, waiting for its mid-bit sample
// DATA   | shifting in DATA_W data bits
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling STOP_BITS stop bits, then deliver or flag
// BREAK  | framing error seen, waiting for the line to return high
module uart_rx_frame
   import uart_rx_pkg::*;
#(
   parameter int DATA_W       = 15,
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1,
   parameter int LSB_FIRST    = 0
) (
   input  logic              clk_rx,
   input  logic              rst_n_rx,
   input  logic              msg_in_rx,
   output logic [DATA_W-1:0] msg_out_rx,
   output logic              valid_rx,
   output logic              frame_err_rx,
   output logic              parity_err_rx,
   output logic              busy_rx
);

   localparam int            HALF      = (CLKS_PER_BIT - 1) / 2;
   localparam int            CW        = count_w(DATA_W);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic              stop_err_q;
   logic              mid, bit_end, restart;
   logic              last_stop, stop_bad, par_bad;
   logic              good_d, frame_d, par_d;
`ifdef UART_RX_PARITY_EN
   logic              par_q;
`endif

   uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk_rx   (clk_rx),
      .rst_n_rx (rst_n_rx),
      .restart  (restart),
      .mid      (mid),
      .bit_end  (bit_end)
   );

   // Every decision here is taken on the mid-bit strike; the bit-end strike is a spare tap.
   logic unused_bit_end;
   assign unused_bit_end = bit_end;

   // State register.
   always_ff @(posedge clk_rx or negedge rst_n_rx) begin
      if (!rst_n_rx) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic. With HALF==0 the IDLE cycle that sees the low line is the start sample.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (!msg_in_rx) state_d = (HALF == 0) ? DATA : START;
         START:  if (mid) state_d = msg_in_rx ? IDLE : DATA;
         DATA:   if (mid && bit_cnt == DATA_LAST)
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
         PARITY: if (mid) state_d = STOP;
         STOP:   if (last_stop) state_d = stop_bad ? BREAK : IDLE;
         BREAK:  if (msg_in_rx) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and decode logic: busy, timer restart, end-of-frame verdict, next shift value.
   always_comb begin
      busy_rx   = (state_q != IDLE);
      restart   = (state_q == IDLE);
      last_stop = (state_q == STOP) && mid && (bit_cnt == STOP_LAST);
      stop_bad  = stop_err_q | ~msg_in_rx;
`ifdef UART_RX_PARITY_EN
      par_bad   = even_par(32'(shreg)) ^ par_q;
`else
      par_bad   = 1'b0;
`endif
      good_d    = last_stop & ~stop_bad & ~par_bad;
      frame_d   = last_stop & stop_bad;
      par_d     = last_stop & par_bad;
      if (LSB_FIRST != 0) shreg_next = (shreg >> 1) | (DATA_W'(msg_in_rx) << (DATA_W - 1));
      else                shreg_next = (shreg << 1) | DATA_W'(msg_in_rx);
   end

   // Datapath: shift register, bit counter, sticky stop error, registered result pulses.
   always_ff @(posedge clk_rx or negedge rst_n_rx) begin
      if (!rst_n_rx) begin
         shreg         <= '1;
         bit_cnt       <= '0;
         stop_err_q    <= 1'b0;
         msg_out_rx    <= '1;
         valid_rx      <= 1'b0;
         frame_err_rx  <= 1'b0;
         parity_err_rx <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q         <= 1'b0;
`endif
      end else begin
         valid_rx      <= good_d;
         frame_err_rx  <= frame_d;
         parity_err_rx <= par_d;
         if (good_d) msg_out_rx <= shreg;
         case (state_q)
            DATA: if (mid) begin
               shreg   <= shreg_next;
               bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + CW'(1);
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) par_q <= msg_in_rx;
`endif
            STOP: if (mid) begin
               stop_err_q <= stop_bad;
               bit_cnt    <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + CW'(1);
            end
            default: begin
               bit_cnt    <= '0;
               stop_err_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame. A frame-level model predicts, from bit positions
// alone, the cycle and kind of every result pulse and the held output word; a compare
// process checks all DUT outputs against it on every cycle. Literal checks pin the model.
// Instance 0: DATA_W=15, 1 clk/bit. Instance 1: DATA_W=15, 8 clk/bit.
// Instance 2 (only with UART_RX_PARITY_EN): DATA_W=8, 1 clk/bit.
module tb_uart_rx_frame;
`ifdef UART_RX_PARITY_EN
   localparam int NDUT = 3;
   localparam int PB   = 1;
   localparam int DW  [3] = '{15, 15, 8};
   localparam int CPB [3] = '{1, 8, 1};
`else
   localparam int NDUT = 2;
   localparam int PB   = 0;
   localparam int DW  [2] = '{15, 15};
   localparam int CPB [2] = '{1, 8};
`endif
   localparam int STOPB = 1;

   typedef struct {
      int          dut;
      int          cyc;
      logic        v;
      logic        fe;
      logic        pe;
      logic [31:0] word;
   } ev_t;

   logic        clk_rx = 1'b0;
   logic        rst_n_rx = 1'b0;
   logic        line [NDUT];
   logic [31:0] mo   [NDUT];
   logic        vld  [NDUT];
   logic        ferr [NDUT];
   logic        perr [NDUT];
   logic        bsy  [NDUT];
   logic [14:0] mo_f, mo_s;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   ev_t evq [$];
   logic [31:0] exp_msg [NDUT];
   int last_v_cyc [NDUT];
   int prev_v_cyc [NDUT];
   logic [31:0] last_v_word [NDUT];
   int last_fe_cyc [NDUT];
   int last_pe_cyc [NDUT];

   always #5 clk_rx = ~clk_rx;
   always @(posedge clk_rx) cyc <= cyc + 1;

   uart_rx_frame #(.DATA_W(15), .CLKS_PER_BIT(1), .STOP_BITS(1), .LSB_FIRST(0)) u_fast (
      .clk_rx(clk_rx), .rst_n_rx(rst_n_rx), .msg_in_rx(line[0]), .msg_out_rx(mo_f),
      .valid_rx(vld[0]), .frame_err_rx(ferr[0]), .parity_err_rx(perr[0]), .busy_rx(bsy[0]));
   uart_rx_frame #(.DATA_W(15), .CLKS_PER_BIT(8), .STOP_BITS(1), .LSB_FIRST(0)) u_slow (
      .clk_rx(clk_rx), .rst_n_rx(rst_n_rx), .msg_in_rx(line[1]), .msg_out_rx(mo_s),
      .valid_rx(vld[1]), .frame_err_rx(ferr[1]), .parity_err_rx(perr[1]), .busy_rx(bsy[1]));
   assign mo[0] = 32'(mo_f);
   assign mo[1] = 32'(mo_s);
`ifdef UART_RX_PARITY_EN
   logic [7:0] mo_p;
   uart_rx_frame #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .LSB_FIRST(0)) u_par (
      .clk_rx(clk_rx), .rst_n_rx(rst_n_rx), .msg_in_rx(line[2]), .msg_out_rx(mo_p),
      .valid_rx(vld[2]), .frame_err_rx(ferr[2]), .parity_err_rx(perr[2]), .busy_rx(bsy[2]));
   assign mo[2] = 32'(mo_p);
`endif

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", name, d, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_rx);
      #1;
   endtask

   // Drive one frame (MSB first) and record the pulse the frame must produce.
   // The last stop-bit level stays on the line when the task returns.
   task automatic send(input int d, input logic [31:0] w, input logic stop_v, input logic par_flip);
      logic bits [$];
      int   c;
      ev_t  e;
      c = CPB[d];
      bits.push_back(1'b0);
      for (int i = 0; i < DW[d]; i++) bits.push_back(w[DW[d] - 1 - i]);
      if (PB == 1) bits.push_back((^w) ^ par_flip);
      for (int i = 0; i < STOPB; i++) bits.push_back(stop_v);
      e.dut  = d;
      e.cyc  = cyc + (bits.size() - 1) * c + (c - 1) / 2 + 1;
      e.fe   = !stop_v;
      e.pe   = (PB == 1) && par_flip;
      e.v    = !e.fe && !e.pe;
      e.word = w;
      evq.push_back(e);
      foreach (bits[i]) begin
         line[d] = bits[i];
         repeat (c) tick();
      end
   endtask

   // Compare every output of every instance against the frame-level model each cycle.
   always @(negedge clk_rx) begin : cmp
      logic ev, ef, ep;
      for (int d = 0; d < NDUT; d++) begin
         ev = 1'b0;
         ef = 1'b0;
         ep = 1'b0;
         if (!rst_n_rx) exp_msg[d] = (32'd1 << DW[d]) - 32'd1;
         for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].dut == d && !rst_n_rx) begin
               evq.delete(i);
            end else if (evq[i].dut == d && evq[i].cyc == cyc) begin
               ev = evq[i].v;
               ef = evq[i].fe;
               ep = evq[i].pe;
               if (evq[i].v) exp_msg[d] = evq[i].word;
               evq.delete(i);
            end
         end
         chk("valid_rx", d, 32'(vld[d]), 32'(ev));
         chk("frame_err_rx", d, 32'(ferr[d]), 32'(ef));
         chk("parity_err_rx", d, 32'(perr[d]), 32'(ep));
         chk("msg_out_rx", d, mo[d], exp_msg[d]);
      end
   end

   // Record when pulses were seen, for the literal timing checks.
   always @(negedge clk_rx) begin : mon
      for (int d = 0; d < NDUT; d++) begin
         if (vld[d] === 1'b1) begin
            prev_v_cyc[d]  = last_v_cyc[d];
            last_v_cyc[d]  = cyc;
            last_v_word[d] = mo[d];
         end
         if (ferr[d] === 1'b1) last_fe_cyc[d] = cyc;
         if (perr[d] === 1'b1) last_pe_cyc[d] = cyc;
      end
   end

   initial begin
      int t;
      for (int d = 0; d < NDUT; d++) begin
         line[d] = 1'b1;
         last_v_cyc[d] = -1;
         prev_v_cyc[d] = -1;
         last_fe_cyc[d] = -1;
         last_pe_cyc[d] = -1;
         last_v_word[d] = '0;
      end
      repeat (3) tick();
      chk("reset_msg", 0, mo[0], 32'h7FFF);
      chk("reset_busy", 1, 32'(bsy[1]), 32'd0);
      chk("reset_valid", 0, 32'(vld[0]), 32'd0);
      rst_n_rx = 1'b1;
      repeat (2) tick();

      // Alternating word at 1 clk/bit: pulse 17 cycles after the start bit.
      t = cyc;
      send(0, 32'h5555, 1'b1, 1'b0);
      repeat (3) tick();
      chk("t1_valid_latency", 0, 32'(last_v_cyc[0] - t), 32'(17 + PB));
      chk("t1_word", 0, last_v_word[0], 32'h5555);

      // Short glitch at 8 clk/bit: false start, busy drops right after the sample.
      line[1] = 1'b0;
      repeat (3) tick();
      line[1] = 1'b1;
      @(negedge clk_rx);
      chk("glitch_busy_at_sample", 1, 32'(bsy[1]), 32'd1);
      tick();
      @(negedge clk_rx);
      chk("glitch_busy_after", 1, 32'(bsy[1]), 32'd0);
      repeat (4) tick();
      send(1, 32'h7001, 1'b1, 1'b0);
      repeat (10) tick();
      chk("slow_word", 1, last_v_word[1], 32'h7001);

      // Low stop bit, line held low: framing error, BREAK until the line recovers.
      t = cyc;
      send(0, 32'h1111, 1'b0, 1'b0);
      repeat (20) tick();
      chk("ferr_latency", 0, 32'(last_fe_cyc[0] - t), 32'(17 + PB));
      chk("break_busy", 0, 32'(bsy[0]), 32'd1);
      chk("ferr_msg_kept", 0, mo[0], 32'h5555);
      line[0] = 1'b1;
      tick();
      @(negedge clk_rx);
      chk("break_exit_busy", 0, 32'(bsy[0]), 32'd0);
      tick();
      send(0, 32'h0ABC, 1'b1, 1'b0);
      repeat (3) tick();
      chk("after_break_word", 0, last_v_word[0], 32'h0ABC);

      // Back-to-back frames with no idle gap.
      t = cyc;
      send(0, 32'h1234, 1'b1, 1'b0);
      send(0, 32'h0FFF, 1'b1, 1'b0);
      repeat (3) tick();
      chk("b2b_first", 0, 32'(prev_v_cyc[0] - t), 32'(17 + PB));
      chk("b2b_gap", 0, 32'(last_v_cyc[0] - prev_v_cyc[0]), 32'(17 + PB));
      chk("b2b_word", 0, last_v_word[0], 32'h0FFF);

      // Asynchronous reset during data bit 7 of 0x1357.
      line[0] = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         line[0] = (15'h1357 >> (14 - i)) & 15'h1;
         tick();
      end
      #1;
      rst_n_rx = 1'b0;
      #1;
      chk("async_rst_msg", 0, mo[0], 32'h7FFF);
      chk("async_rst_busy", 0, 32'(bsy[0]), 32'd0);
      chk("async_rst_slow_msg", 1, mo[1], 32'h7FFF);
      repeat (2) tick();
      line[0] = 1'b1;
      tick();
      rst_n_rx = 1'b1;
      repeat (2) tick();
      send(0, 32'h2AAA, 1'b1, 1'b0);
      repeat (3) tick();
      chk("post_rst_word", 0, last_v_word[0], 32'h2AAA);

`ifdef UART_RX_PARITY_EN
      // 0xA5 has even weight: parity bit 1 is wrong, parity bit 0 is right.
      t = cyc;
      send(2, 32'hA5, 1'b1, 1'b1);
      repeat (3) tick();
      chk("par_err_latency", 2, 32'(last_pe_cyc[2] - t), 32'd11);
      chk("par_err_msg_kept", 2, mo[2], 32'hFF);
      send(2, 32'hA5, 1'b1, 1'b0);
      repeat (3) tick();
      chk("par_ok_word", 2, last_v_word[2], 32'hA5);
`endif

      repeat (5) tick();
      chk("events_drained", 0, 32'(evq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
